// File: rtl/bcnn_pkg.sv
// Shared types and helpers for the binary convolution layer: FSM states,
// popcount width and the window bit-index mapping.
package bcnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Bits needed to hold a popcount of n bits (0..n inclusive).
    function automatic int popcnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Row r = 0 is the oldest row, column c = 0 the leftmost column.
    function automatic int win_index(input int r, input int c, input int ch,
                                     input int k, input int c_in);
        return (r * k + c) * c_in + ch;
    endfunction

endpackage

// File: rtl/bcnn_window_buffer.sv
// K-1 line buffers plus a KxK shift window of C_IN-bit pixels; the window
// register is pipeline stage S1 and holds while stalled.
module bcnn_window_buffer
    import bcnn_pkg::*;
#(
    parameter int IMG_WIDTH   = 13,
    parameter int KERNEL_SIZE = 3,
    parameter int C_IN        = 4,
    localparam int COL_W      = $clog2(IMG_WIDTH),
    localparam int WIN_BITS   = KERNEL_SIZE * KERNEL_SIZE * C_IN
) (
    input  logic                clk,
    input  logic                rst_n_i,
    input  logic                en_i,
    input  logic                stall_i,
    input  logic [COL_W-1:0]    col_i,
    input  logic [C_IN-1:0]     pix_i,
    input  logic                win_cond_i,
    input  logic                last_i,
    output logic [WIN_BITS-1:0] win_o,
    output logic                win_valid_o,
    output logic                win_last_o
);

    logic [C_IN-1:0] tap     [KERNEL_SIZE];
    logic [C_IN-1:0] line_rd [KERNEL_SIZE-1];
    logic [C_IN-1:0] win_q   [KERNEL_SIZE][KERNEL_SIZE];
    logic            win_valid_q;
    logic            win_last_q;

    assign tap[KERNEL_SIZE-1] = pix_i;

    genvar gi, gj;
    generate
        // Line 0 holds the previous row; each later line is fed from the one before.
        for (gi = 0; gi < KERNEL_SIZE - 1; gi++) begin : g_line
            logic [C_IN-1:0] mem [IMG_WIDTH];
            logic [C_IN-1:0] wr_data;

            assign line_rd[gi]             = mem[col_i];
            assign tap[KERNEL_SIZE-2-gi]   = line_rd[gi];

            if (gi == 0) begin : g_head
                assign wr_data = pix_i;
            end else begin : g_chain
                assign wr_data = line_rd[gi-1];
            end

            always_ff @(posedge clk) begin
                if (en_i) begin
                    mem[col_i] <= wr_data;
                end
            end
        end

        for (gi = 0; gi < KERNEL_SIZE; gi++) begin : g_row
            for (gj = 0; gj < KERNEL_SIZE; gj++) begin : g_col
                localparam int BIT_LO = win_index(gi, gj, 0, KERNEL_SIZE, C_IN);
                assign win_o[BIT_LO +: C_IN] = win_q[gi][gj];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else if (!stall_i) begin
            win_valid_q <= en_i && win_cond_i;
            win_last_q  <= en_i && last_i;
            if (en_i) begin
                for (int r = 0; r < KERNEL_SIZE; r++) begin
                    for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                        win_q[r][c] <= win_q[r][c+1];
                    end
                    win_q[r][KERNEL_SIZE-1] <= tap[r];
                end
            end
        end
    end

    assign win_valid_o = win_valid_q;
    assign win_last_o  = win_last_q;

endmodule

// File: rtl/bcnn_conv_multich_layer.sv
// Streaming KxK binary conv layer, C_IN -> C_OUT channels, XNOR-popcount + threshold.
// Define BCNN_RAW_SUM_EN to expose the per-channel popcounts on sum_out.
module bcnn_conv_multich_layer
    import bcnn_pkg::*;
#(
    parameter int IMG_WIDTH   = 13,
    parameter int IMG_HEIGHT  = 13,
    parameter int KERNEL_SIZE = 3,
    parameter int C_IN        = 4,
    parameter int C_OUT       = 8,
    parameter int SUM_WIDTH   = popcnt_width(KERNEL_SIZE * KERNEL_SIZE * C_IN),
    localparam int ADDR_W     = (C_OUT > 1) ? $clog2(C_OUT) : 1,
    localparam int WIN_BITS   = KERNEL_SIZE * KERNEL_SIZE * C_IN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [ADDR_W-1:0]    cfg_addr,
    input  logic [WIN_BITS-1:0]  cfg_weight,
    input  logic [SUM_WIDTH-1:0] cfg_thresh,
    output logic                 cfg_err,
    input  logic [C_IN-1:0]      pixel_in,
    input  logic                 valid_in,
    output logic                 pixel_ready,
    output logic [C_OUT-1:0]     act_out,
    output logic                 valid_out,
    input  logic                 out_ready,
    output logic                 out_last
`ifdef BCNN_RAW_SUM_EN
    ,
    output logic [C_OUT*SUM_WIDTH-1:0] sum_out
`endif
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_K1   = COL_W'(KERNEL_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_K1   = ROW_W'(KERNEL_SIZE - 1);

    state_e                state_q;
    logic [ROW_W-1:0]      row_q;
    logic [COL_W-1:0]      col_q;
    logic                  cfg_err_q;
    logic [WIN_BITS-1:0]   weight_q [C_OUT];
    logic [SUM_WIDTH-1:0]  thresh_q [C_OUT];

    logic                  s2_valid_q, s2_last_q;
    logic                  valid_q, last_q;

    logic                  stall, accept, last_pix, win_cond;
    logic [WIN_BITS-1:0]   win;
    logic                  win_valid, win_last;

    assign stall       = valid_q && !out_ready;
    assign pixel_ready = !stall;
    assign accept      = valid_in && pixel_ready;
    assign last_pix    = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign win_cond    = (row_q >= ROW_K1) && (col_q >= COL_K1);

    bcnn_window_buffer #(
        .IMG_WIDTH   (IMG_WIDTH),
        .KERNEL_SIZE (KERNEL_SIZE),
        .C_IN        (C_IN)
    ) u_window (
        .clk         (clk),
        .rst_n_i     (reset),
        .en_i        (accept),
        .stall_i     (stall),
        .col_i       (col_q),
        .pix_i       (pixel_in),
        .win_cond_i  (win_cond),
        .last_i      (last_pix),
        .win_o       (win),
        .win_valid_o (win_valid),
        .win_last_o  (win_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            if (accept) begin
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
            case (state_q)
                ST_IDLE: if (accept) state_q <= ST_RUN;
                ST_RUN:  if (accept && last_pix) state_q <= ST_DRAIN;
                ST_DRAIN: begin
                    // A next frame already under way (this cycle or earlier) keeps us out of IDLE.
                    if (valid_q && out_ready && last_q) begin
                        state_q <= (accept || row_q != '0 || col_q != '0) ? ST_RUN : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_err_q <= 1'b0;
            for (int o = 0; o < C_OUT; o++) begin
                weight_q[o] <= '0;
                thresh_q[o] <= '0;
            end
        end else begin
            cfg_err_q <= cfg_we && (state_q != ST_IDLE);
            if (cfg_we && state_q == ST_IDLE && int'(cfg_addr) < C_OUT) begin
                weight_q[cfg_addr] <= cfg_weight;
                thresh_q[cfg_addr] <= cfg_thresh;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else if (!stall) begin
            s2_valid_q <= win_valid;
            s2_last_q  <= win_valid && win_last;
            valid_q    <= s2_valid_q;
            last_q     <= s2_valid_q && s2_last_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < C_OUT; gi++) begin : g_ch
            logic [WIN_BITS-1:0]  match;
            logic [SUM_WIDTH-1:0] sum_d;
            logic [SUM_WIDTH-1:0] sum_q;
            logic                 act_q;
`ifdef BCNN_RAW_SUM_EN
            logic [SUM_WIDTH-1:0] sum_out_q;
`endif

            always_comb begin
                match = ~(win ^ weight_q[gi]);
                sum_d = '0;
                for (int b = 0; b < WIN_BITS; b++) begin
                    sum_d = sum_d + SUM_WIDTH'(match[b]);
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sum_q <= '0;
                    act_q <= 1'b0;
`ifdef BCNN_RAW_SUM_EN
                    sum_out_q <= '0;
`endif
                end else if (!stall) begin
                    if (win_valid) sum_q <= sum_d;
                    if (s2_valid_q) begin
                        act_q <= (sum_q >= thresh_q[gi]);
`ifdef BCNN_RAW_SUM_EN
                        sum_out_q <= sum_q;
`endif
                    end
                end
            end

            assign act_out[gi] = act_q;
`ifdef BCNN_RAW_SUM_EN
            assign sum_out[gi*SUM_WIDTH +: SUM_WIDTH] = sum_out_q;
`endif
        end
    endgenerate

    assign valid_out = valid_q;
    assign out_last  = last_q;
    assign cfg_err   = cfg_err_q;

endmodule
